// File: rtl/hpdcache_mshr_sched_if.sv
// Purpose: bundles miss, refill-ack and MSHR command/result signals of the MSHR scheduler.
// Latency: none, wiring only.
// Backpressure: carries miss/ack valid-ready pairs; the MSHR side has no backpressure.
interface hpdcache_mshr_sched_if #(
  parameter int unsigned SetWidth     = 6,
  parameter int unsigned TagWidth     = 20,
  parameter int unsigned MshrSetWidth = 1,
  parameter int unsigned MshrWayWidth = 2,
  parameter int unsigned PayloadWidth = 16
);
  // miss requester
  logic                          miss_valid_i;
  logic                          miss_ready_o;
  logic [SetWidth-1:0]           miss_set_i;
  logic [TagWidth-1:0]           miss_tag_i;
  logic [PayloadWidth-1:0]       miss_payload_i;
  logic                          miss_rsp_valid_o;
  logic [1:0]                    miss_rsp_status_o;
  logic [MshrWayWidth-1:0]       miss_rsp_way_o;
  // refill ack requester
  logic                          ack_valid_i;
  logic                          ack_ready_o;
  logic [MshrSetWidth-1:0]       ack_set_i;
  logic [MshrWayWidth-1:0]       ack_way_i;
  logic                          ack_rsp_valid_o;
  // MSHR command / result
  logic                          mshr_check_o;
  logic [SetWidth-1:0]           mshr_check_set_o;
  logic [TagWidth-1:0]           mshr_check_tag_o;
  logic                          mshr_hit_i;
  logic                          mshr_alloc_full_i;
  logic [MshrWayWidth-1:0]       mshr_alloc_way_i;
  logic                          mshr_alloc_o;
  logic                          mshr_alloc_cs_o;
  logic [SetWidth+TagWidth-1:0]  mshr_alloc_nline_o;
  logic [PayloadWidth-1:0]       mshr_alloc_payload_o;
  logic                          mshr_ack_o;
  logic                          mshr_ack_cs_o;
  logic [MshrSetWidth-1:0]       mshr_ack_set_o;
  logic [MshrWayWidth-1:0]       mshr_ack_way_o;
  logic                          busy_o;

  // requesters and MSHR model drive the inputs, observe the outputs
  modport master (
    output miss_valid_i, miss_set_i, miss_tag_i, miss_payload_i,
    output ack_valid_i, ack_set_i, ack_way_i,
    output mshr_hit_i, mshr_alloc_full_i, mshr_alloc_way_i,
    input  miss_ready_o, miss_rsp_valid_o, miss_rsp_status_o, miss_rsp_way_o,
    input  ack_ready_o, ack_rsp_valid_o,
    input  mshr_check_o, mshr_check_set_o, mshr_check_tag_o,
    input  mshr_alloc_o, mshr_alloc_cs_o, mshr_alloc_nline_o, mshr_alloc_payload_o,
    input  mshr_ack_o, mshr_ack_cs_o, mshr_ack_set_o, mshr_ack_way_o,
    input  busy_o
  );

  // the scheduler
  modport slave (
    input  miss_valid_i, miss_set_i, miss_tag_i, miss_payload_i,
    input  ack_valid_i, ack_set_i, ack_way_i,
    input  mshr_hit_i, mshr_alloc_full_i, mshr_alloc_way_i,
    output miss_ready_o, miss_rsp_valid_o, miss_rsp_status_o, miss_rsp_way_o,
    output ack_ready_o, ack_rsp_valid_o,
    output mshr_check_o, mshr_check_set_o, mshr_check_tag_o,
    output mshr_alloc_o, mshr_alloc_cs_o, mshr_alloc_nline_o, mshr_alloc_payload_o,
    output mshr_ack_o, mshr_ack_cs_o, mshr_ack_set_o, mshr_ack_way_o,
    output busy_o
  );
endinterface

// File: rtl/hpdcache_mshr_sched.sv
// Purpose: serialises miss check/alloc and refill ack commands onto the single MSHR command port.
// Latency: miss check at accept cycle, outcome/alloc 1 cycle later; ack cmd at accept, ack rsp 1 cycle later.
// Backpressure: miss_ready/ack_ready drop while evaluating or when the other requester wins; ack starvation bounded.
module hpdcache_mshr_sched #(
  parameter int unsigned SetWidth     = 6,
  parameter int unsigned TagWidth     = 20,
  parameter int unsigned MshrSetWidth = 1,
  parameter int unsigned MshrWayWidth = 2,
  parameter int unsigned PayloadWidth = 16,
  parameter int unsigned AckStarveMax = 4
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  hpdcache_mshr_sched_if.slave  bus
);
  localparam int unsigned StarveW = $clog2(AckStarveMax + 1);
  localparam logic [StarveW-1:0] StarveMaxV = StarveW'(AckStarveMax);

  localparam logic [1:0] StAlloc = 2'b00;
  localparam logic [1:0] StHit   = 2'b01;
  localparam logic [1:0] StFull  = 2'b10;

  typedef enum logic {IDLE, EVAL} state_e;

  state_e                  state_q;
  logic [StarveW-1:0]      starve_q;
  logic [SetWidth-1:0]     set_q;
  logic [TagWidth-1:0]     tag_q;
  logic [PayloadWidth-1:0] payload_q;
  logic                    ack_rsp_q;

  logic in_idle;
  logic in_eval;
  logic ack_wins;
  logic miss_acc;
  logic ack_acc;
  logic do_alloc;

  // Outputs are qualified by rst_ni so every output reads 0 while reset is held,
  // including mid-EVAL where this suppresses the response and the alloc.
  assign in_idle  = rst_ni && (state_q == IDLE);
  assign in_eval  = rst_ni && (state_q == EVAL);
  assign ack_wins = bus.ack_valid_i && (!bus.miss_valid_i || (starve_q == StarveMaxV));
  assign miss_acc = bus.miss_valid_i && bus.miss_ready_o;
  assign ack_acc  = bus.ack_valid_i && bus.ack_ready_o;
  assign do_alloc = in_eval && !bus.mshr_hit_i && !bus.mshr_alloc_full_i;

  assign bus.miss_ready_o    = in_idle && !ack_wins;
  assign bus.ack_ready_o     = in_idle && (ack_wins || !bus.miss_valid_i);
  assign bus.ack_rsp_valid_o = ack_rsp_q;
  assign bus.busy_o          = in_eval;

  // Command and response decode: check/ack only from IDLE, alloc/outcome only from EVAL,
  // so check/alloc and ack can never coincide.
  always_comb begin
    bus.mshr_check_o         = miss_acc;
    bus.mshr_check_set_o     = '0;
    bus.mshr_check_tag_o     = '0;
    bus.mshr_alloc_o         = do_alloc;
    bus.mshr_alloc_cs_o      = do_alloc;
    bus.mshr_alloc_nline_o   = '0;
    bus.mshr_alloc_payload_o = '0;
    bus.mshr_ack_o           = ack_acc;
    bus.mshr_ack_cs_o        = ack_acc;
    bus.mshr_ack_set_o       = '0;
    bus.mshr_ack_way_o       = '0;
    bus.miss_rsp_valid_o     = in_eval;
    bus.miss_rsp_status_o    = StAlloc;
    bus.miss_rsp_way_o       = '0;
    if (rst_ni) begin
      bus.mshr_ack_set_o = bus.ack_set_i;
      bus.mshr_ack_way_o = bus.ack_way_i;
    end
    if (in_idle) begin
      bus.mshr_check_set_o = bus.miss_set_i;
      bus.mshr_check_tag_o = bus.miss_tag_i;
    end
    if (in_eval) begin
      // the MSHR compares the latched tag during this cycle
      bus.mshr_check_set_o = set_q;
      bus.mshr_check_tag_o = tag_q;
      if (bus.mshr_hit_i) begin
        bus.miss_rsp_status_o = StHit;
      end else if (bus.mshr_alloc_full_i) begin
        bus.miss_rsp_status_o = StFull;
      end else begin
        bus.miss_rsp_status_o    = StAlloc;
        bus.miss_rsp_way_o       = bus.mshr_alloc_way_i;
        bus.mshr_alloc_nline_o   = {tag_q, set_q};
        bus.mshr_alloc_payload_o = payload_q;
      end
    end
  end

  // FSM, miss latch, ack response strobe and ack starvation counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      set_q     <= '0;
      tag_q     <= '0;
      payload_q <= '0;
      ack_rsp_q <= 1'b0;
    end else begin
      ack_rsp_q <= ack_acc;

      if (bus.ack_valid_i && !ack_acc) begin
        if (starve_q != StarveMaxV) begin
          starve_q <= starve_q + 1'b1;
        end
      end else begin
        starve_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (miss_acc) begin
            set_q     <= bus.miss_set_i;
            tag_q     <= bus.miss_tag_i;
            payload_q <= bus.miss_payload_i;
            state_q   <= EVAL;
          end
        end
        EVAL: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hpdcache_mshr_sched.sv
// Purpose: directed, table-driven self-checking bench for the MSHR scheduler.
// Latency: one vector per clock; inputs driven 1ns after posedge, outputs sampled at negedge.
// Backpressure: exercised through miss/ack arbitration, EVAL stalls and ack starvation.
module tb_hpdcache_mshr_sched;
  localparam logic [1:0] ST_ALLOC = 2'b00;
  localparam logic [1:0] ST_HIT   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hpdcache_mshr_sched_if #(
    .SetWidth(6), .TagWidth(20), .MshrSetWidth(1), .MshrWayWidth(2), .PayloadWidth(16)
  ) bus ();

  hpdcache_mshr_sched #(
    .SetWidth(6), .TagWidth(20), .MshrSetWidth(1), .MshrWayWidth(2),
    .PayloadWidth(16), .AckStarveMax(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        mrdy;
    logic        chk;
    logic [5:0]  cset;
    logic        rspv;
    logic [1:0]  st;
    logic [1:0]  way;
    logic        alloc;
    logic [25:0] nline;
    logic [15:0] pl;
    logic        ardy;
    logic        mack;
    logic        arspv;
    logic        busy;
  } exp_t;

  typedef struct {
    string       name;
    logic        mv;
    logic [5:0]  ms;
    logic [19:0] mt;
    logic [15:0] mp;
    logic        av;
    logic        as;
    logic [1:0]  aw;
    logic        hit;
    logic        full;
    logic [1:0]  fw;
    exp_t        e;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(
    input string n, input logic mv, input logic [5:0] ms, input logic [19:0] mt, input logic [15:0] mp,
    input logic av, input logic as, input logic [1:0] aw,
    input logic hit, input logic full, input logic [1:0] fw,
    input logic mrdy, input logic chk_e, input logic [5:0] cset, input logic rspv,
    input logic [1:0] st, input logic [1:0] way, input logic alloc,
    input logic [25:0] nline, input logic [15:0] pl,
    input logic ardy, input logic mack, input logic arspv, input logic busy);
    vec_t v;
    v.name = n; v.mv = mv; v.ms = ms; v.mt = mt; v.mp = mp;
    v.av = av; v.as = as; v.aw = aw; v.hit = hit; v.full = full; v.fw = fw;
    v.e = '{mrdy: mrdy, chk: chk_e, cset: cset, rspv: rspv, st: st, way: way, alloc: alloc,
            nline: nline, pl: pl, ardy: ardy, mack: mack, arspv: arspv, busy: busy};
    return v;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a = '{mrdy: bus.miss_ready_o, chk: bus.mshr_check_o, cset: bus.mshr_check_set_o,
          rspv: bus.miss_rsp_valid_o, st: bus.miss_rsp_status_o, way: bus.miss_rsp_way_o,
          alloc: bus.mshr_alloc_o, nline: bus.mshr_alloc_nline_o, pl: bus.mshr_alloc_payload_o,
          ardy: bus.ack_ready_o, mack: bus.mshr_ack_o, arspv: bus.ack_rsp_valid_o, busy: bus.busy_o};
    return a;
  endfunction

  function automatic logic [127:0] all_out();
    return 128'({bus.miss_ready_o, bus.miss_rsp_valid_o, bus.miss_rsp_status_o, bus.miss_rsp_way_o,
                 bus.ack_ready_o, bus.ack_rsp_valid_o, bus.mshr_check_o, bus.mshr_check_set_o,
                 bus.mshr_check_tag_o, bus.mshr_alloc_o, bus.mshr_alloc_cs_o, bus.mshr_alloc_nline_o,
                 bus.mshr_alloc_payload_o, bus.mshr_ack_o, bus.mshr_ack_cs_o, bus.mshr_ack_set_o,
                 bus.mshr_ack_way_o, bus.busy_o});
  endfunction

  task automatic drive(input logic mv, input logic [5:0] ms, input logic [19:0] mt, input logic [15:0] mp,
                       input logic av, input logic as, input logic [1:0] aw,
                       input logic hit, input logic full, input logic [1:0] fw);
    bus.miss_valid_i = mv; bus.miss_set_i = ms; bus.miss_tag_i = mt; bus.miss_payload_i = mp;
    bus.ack_valid_i = av; bus.ack_set_i = as; bus.ack_way_i = aw;
    bus.mshr_hit_i = hit; bus.mshr_alloc_full_i = full; bus.mshr_alloc_way_i = fw;
  endtask

  initial begin
    exp_t act;

    // mk(name, mv,ms,mt,mp, av,as,aw, hit,full,fw,  mrdy,chk,cset,rspv,st,way,alloc,nline,pl, ardy,mack,arspv,busy)
    vecs.push_back(mk("idle",       0,0,0,0,             0,0,0, 0,0,0, 1,0,0,0,0,0,0,0,0,                               1,0,0,0));
    vecs.push_back(mk("t1_check",   1,5,'hABC,'h1234,    0,0,0, 0,0,0, 1,1,5,0,0,0,0,0,0,                               0,0,0,0));
    vecs.push_back(mk("t1_alloc",   0,0,0,0,             0,0,0, 0,0,2, 0,0,5,1,ST_ALLOC,2,1,{20'hABC,6'd5},'h1234,      0,0,0,1));
    vecs.push_back(mk("t2_check",   1,9,'h111,'h55AA,    0,0,0, 0,0,0, 1,1,9,0,0,0,0,0,0,                               0,0,0,0));
    vecs.push_back(mk("t2_hit",     0,0,0,0,             0,0,0, 1,1,1, 0,0,9,1,ST_HIT,0,0,0,0,                          0,0,0,1));
    vecs.push_back(mk("t3_ack",     0,0,0,0,             1,1,3, 0,0,0, 0,0,0,0,0,0,0,0,0,                               1,1,0,0));
    vecs.push_back(mk("t3_rsp",     0,0,0,0,             0,0,0, 0,0,0, 1,0,0,0,0,0,0,0,0,                               1,0,1,0));
    vecs.push_back(mk("t3_quiet",   0,0,0,0,             0,0,0, 0,0,0, 1,0,0,0,0,0,0,0,0,                               1,0,0,0));
    vecs.push_back(mk("t6_check",   1,3,'hF0F0,'h0F0F,   0,0,0, 0,0,0, 1,1,3,0,0,0,0,0,0,                               0,0,0,0));
    vecs.push_back(mk("t6_full",    0,0,0,0,             0,0,0, 0,1,2, 0,0,3,1,ST_FULL,0,0,0,0,                         0,0,0,1));
    vecs.push_back(mk("t6_ack",     0,0,0,0,             1,0,1, 0,0,0, 0,0,0,0,0,0,0,0,0,                               1,1,0,0));
    vecs.push_back(mk("t6_replay",  1,3,'hF0F0,'h0F0F,   0,0,0, 0,0,0, 1,1,3,0,0,0,0,0,0,                               0,0,1,0));
    vecs.push_back(mk("t6_alloc",   0,0,0,0,             0,0,0, 0,0,1, 0,0,3,1,ST_ALLOC,1,1,{20'hF0F0,6'd3},'h0F0F,     0,0,0,1));
    vecs.push_back(mk("t4_m0_chk",  1,1,1,1,             1,0,0, 0,0,0, 1,1,1,0,0,0,0,0,0,                               0,0,0,0));
    vecs.push_back(mk("t4_m0_eval", 1,1,1,1,             1,0,0, 0,0,0, 0,0,1,1,ST_ALLOC,0,1,{20'd1,6'd1},1,             0,0,0,1));
    vecs.push_back(mk("t4_m1_chk",  1,2,2,2,             1,0,0, 0,0,0, 1,1,2,0,0,0,0,0,0,                               0,0,0,0));
    vecs.push_back(mk("t4_m1_eval", 1,2,2,2,             1,0,0, 0,0,3, 0,0,2,1,ST_ALLOC,3,1,{20'd2,6'd2},2,             0,0,0,1));
    vecs.push_back(mk("t4_ack_win", 1,2,2,2,             1,0,0, 0,0,0, 0,0,2,0,0,0,0,0,0,                               1,1,0,0));
    vecs.push_back(mk("t4_m2_chk",  1,4,4,4,             1,0,0, 0,0,0, 1,1,4,0,0,0,0,0,0,                               0,0,1,0));
    vecs.push_back(mk("t4_m2_eval", 0,0,0,0,             0,0,0, 0,0,2, 0,0,4,1,ST_ALLOC,2,1,{20'd4,6'd4},4,             0,0,0,1));

    // Reset state, with active-looking inputs so gating is visible.
    drive(1, 6'd7, 20'h123, 16'hBEEF, 1, 1, 2'd3, 0, 0, 2'd2);
    #3 chk("reset_all_zero", all_out(), '0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Table-driven sequence.
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].mv, vecs[i].ms, vecs[i].mt, vecs[i].mp, vecs[i].av, vecs[i].as, vecs[i].aw,
            vecs[i].hit, vecs[i].full, vecs[i].fw);
      #4;
      act = sample();
      chk(vecs[i].name, 128'(act), 128'(vecs[i].e));
      chk({vecs[i].name, "_cs"}, 128'({bus.mshr_alloc_cs_o, bus.mshr_ack_cs_o}),
          128'({vecs[i].e.alloc, vecs[i].e.mack}));
      chk({vecs[i].name, "_excl"}, 128'(bus.mshr_ack_o && (bus.mshr_check_o || bus.mshr_alloc_o)), 0);
      if (vecs[i].e.mack)
        chk({vecs[i].name, "_ack_tgt"}, 128'({bus.mshr_ack_set_o, bus.mshr_ack_way_o}),
            128'({vecs[i].as, vecs[i].aw}));
    end

    // Reset asserted during EVAL.
    @(posedge clk); #1;
    drive(1, 6'd7, 20'h77, 16'h7777, 1, 1, 2'd2, 0, 0, 2'd3);
    #4 chk("rst_seq_check", 128'({bus.mshr_check_o, bus.mshr_check_set_o}), 128'({1'b1, 6'd7}));
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 1, 2'd2, 0, 0, 2'd3);
    chk("eval_tag", 128'({bus.busy_o, bus.mshr_check_tag_o}), 128'({1'b1, 20'h77}));
    rst_n = 1'b0;
    #1 chk("rst_mid_eval_zero", all_out(), '0);
    @(posedge clk); #1;
    chk("rst_held_zero", all_out(), '0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3);
    rst_n = 1'b1;
    #4 chk("post_rst_idle", 128'({bus.busy_o, bus.miss_rsp_valid_o, bus.mshr_alloc_o, bus.miss_ready_o}),
           128'(4'b0001));
    @(posedge clk); #1;
    drive(1, 6'd8, 20'h88, 16'h8888, 0, 0, 0, 0, 0, 0);
    #4 chk("post_rst_check", 128'({bus.mshr_check_o, bus.mshr_check_set_o, bus.mshr_check_tag_o}),
           128'({1'b1, 6'd8, 20'h88}));
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1);
    #4 chk("post_rst_alloc",
           128'({bus.miss_rsp_valid_o, bus.miss_rsp_status_o, bus.miss_rsp_way_o, bus.mshr_alloc_o,
                 bus.mshr_alloc_nline_o, bus.mshr_alloc_payload_o}),
           128'({1'b1, ST_ALLOC, 2'd1, 1'b1, {20'h88, 6'd8}, 16'h8888}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
